// File: rtl/sort4_ctrl.sv
// sort4_ctrl: four-entry in-place bubble sorter around one shared 10-bit
// less_or_eq comparator. One compare-and-conditional-swap per clock.
// Optional feature macro: SORT_EARLY_EXIT_EN (finish after the first pass
// that makes no swap). Results are identical with or without it.

module less_or_eq #(
  parameter int W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out
);
  assign out = (a <= b);
endmodule

module sort4_ctrl #(
  parameter bit DESC = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [39:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [39:0] out_data,
  output logic [2:0]  out_swaps,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t          state, state_nx;
  logic [3:0][9:0] r;
  logic [1:0]      pass, idx, idx_hi;
  logic [2:0]      swaps;
  logic            pass_swapped;
  logic [9:0]      lo_val, hi_val, cmp_a, cmp_b;
  logic            le, do_swap, pass_end, sort_end, accept;

  // Pair under test: r[idx] (lower slot) and r[idx+1] (upper slot).
  assign idx_hi = idx + 2'd1;
  assign lo_val = r[idx];
  assign hi_val = r[idx_hi];

  // Descending order just swaps comparator operands; "out=0" always means
  // the pair is out of order, and equal values never move (stable).
  assign cmp_a = DESC ? hi_val : lo_val;
  assign cmp_b = DESC ? lo_val : hi_val;

  less_or_eq #(.W(10)) u_cmp (
    .a   (cmp_a),
    .b   (cmp_b),
    .out (le)
  );

  assign do_swap  = (state == SORT) && !le;
  // Pass p covers idx 0..(2-p).
  assign pass_end = (idx == (2'd2 - pass));

`ifdef SORT_EARLY_EXIT_EN
  // A clean pass (including this cycle's compare) means the vector is sorted.
  assign sort_end = pass_end && ((pass == 2'd2) || !(pass_swapped || do_swap));
`else
  assign sort_end = pass_end && (pass == 2'd2);
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == SORT);
  assign accept    = in_valid && in_ready;
  assign out_data  = r;
  assign out_swaps = swaps;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = SORT;
      SORT:    if (sort_end)  state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture on accept, then one compare/swap per SORT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r            <= '0;
      pass         <= '0;
      idx          <= '0;
      swaps        <= '0;
      pass_swapped <= 1'b0;
    end else if (accept) begin
      r            <= in_data;
      pass         <= '0;
      idx          <= '0;
      swaps        <= '0;
      pass_swapped <= 1'b0;
    end else if (state == SORT) begin
      if (do_swap) begin
        r[idx]       <= hi_val;
        r[idx_hi]    <= lo_val;
        swaps        <= swaps + 3'd1;
        pass_swapped <= 1'b1;
      end
      if (pass_end) begin
        idx          <= '0;
        pass         <= pass + 2'd1;
        pass_swapped <= 1'b0;
      end else begin
        idx          <= idx + 2'd1;
      end
    end
  end

endmodule
